// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and the internal BCD sizing rule for the
// sequential binary-to-BCD converter.
package vga_pkg;

  localparam int N = 10;
  localparam int BITPERCH = 4;
  localparam logic [3:0] BLANK_CODE = 4'hA;
  localparam logic [3:0] OVF_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // 4*ceil(n*log10(2))+4 bits; 30103/100000 approximates log10(2).
  function automatic int bcd_width(input int n);
    return BITPERCH * ((n * 30103 + 99999) / 100000) + BITPERCH;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import vga_pkg::*;
(
  input  logic [BITPERCH-1:0] digit_i,
  output logic [BITPERCH-1:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with valid/ready handshakes,
// overflow saturation and optional leading-zero blanking.
//
// state | meaning
// IDLE  | in_ready high, waiting for in_valid
// SHIFT | one double-dabble step per cycle, N steps
// DONE  | out_valid high, result held until out_ready
module bin2bcd_seq #(
  parameter int N        = vga_pkg::N,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_dec,
  output logic                  out_ovf,
  output logic                  busy
);
  import vga_pkg::*;

  localparam int BW   = bcd_width(N);
  localparam int NDIG = BW / BITPERCH;
  localparam int CW   = $clog2(N + 1);
  localparam int OW   = BITPERCH * DIGITS;
  localparam int EW   = (BW > OW) ? BW : OW;

  state_t          state_q, state_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [N-1:0]    sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   dec_q, dec_d;
  logic            ovf_q, ovf_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;

  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_shift;
  logic [EW-1:0]   bcd_ext;
  logic [OW-1:0]   dec_fmt;
  logic            ovf_fmt;
  logic [3:0]      digit;
  logic            lead;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_q[g*BITPERCH +: BITPERCH]),
      .digit_o (bcd_adj[g*BITPERCH +: BITPERCH])
    );
  end

  assign bcd_shift = (bcd_adj << 1) | BW'(sh_q[N-1]);
  assign bcd_ext   = EW'(bcd_shift);

  // Formats the accumulator as it will look after the final shift, so the
  // result register can load in the same edge that enters DONE.
  always_comb begin
    ovf_fmt = 1'b0;
    dec_fmt = '0;
    lead    = 1'b1;
    digit   = 4'h0;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= DIGITS && bcd_ext[i*BITPERCH +: BITPERCH] != 4'h0) ovf_fmt = 1'b1;
    end
    for (int i = DIGITS - 1; i >= 0; i--) begin
      digit = bcd_ext[i*BITPERCH +: BITPERCH];
      if (BLANK_LZ && lead && digit == 4'h0 && i != 0) begin
        dec_fmt[i*BITPERCH +: BITPERCH] = BLANK_CODE;
      end else begin
        dec_fmt[i*BITPERCH +: BITPERCH] = digit;
        lead = 1'b0;
      end
    end
    if (ovf_fmt) dec_fmt = {DIGITS{OVF_CODE}};
  end

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_bin;
          bcd_d   = '0;
          cnt_d   = CW'(N);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_shift;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          dec_d   = dec_fmt;
          ovf_d   = ovf_fmt;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      bcd_q       <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      dec_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_dec   = dec_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and randomized bench for bin2bcd_seq: instance 0 plain, instance 1
// with leading-zero blanking, both checked against a decimal reference model.
module tb_bin2bcd_seq;

  localparam int N = 10;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic RST;
  logic [1:0]        in_valid;
  logic [1:0]        out_ready;
  logic [1:0][N-1:0] in_bin;

  logic in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic out_ovf_a, out_ovf_b, busy_a, busy_b;
  logic [11:0] out_dec_a, out_dec_b;

  logic [1:0]        in_ready, out_valid, out_ovf, busy;
  logic [1:0][11:0]  out_dec;

  assign in_ready  = {in_ready_b, in_ready_a};
  assign out_valid = {out_valid_b, out_valid_a};
  assign out_ovf   = {out_ovf_b, out_ovf_a};
  assign busy      = {busy_b, busy_a};
  assign out_dec   = {out_dec_b, out_dec_a};

  bin2bcd_seq #(.N(N), .DIGITS(DIGITS), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .RST(RST), .in_valid(in_valid[0]), .in_ready(in_ready_a),
    .in_bin(in_bin[0]), .out_valid(out_valid_a), .out_ready(out_ready[0]),
    .out_dec(out_dec_a), .out_ovf(out_ovf_a), .busy(busy_a)
  );

  bin2bcd_seq #(.N(N), .DIGITS(DIGITS), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .RST(RST), .in_valid(in_valid[1]), .in_ready(in_ready_b),
    .in_bin(in_bin[1]), .out_valid(out_valid_b), .out_ready(out_ready[1]),
    .out_dec(out_dec_b), .out_ovf(out_ovf_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int hs_cnt = 0;
  int conv_cnt = 0;
  int perm [1024];
  int tmp, j;
  bit ok;

  always @(posedge clk) begin
    if (!RST && out_valid[0] && out_ready[0]) hs_cnt++;
  end

  function automatic logic [11:0] ref_dec(input int v, input bit blank);
    int d2, d1, d0;
    logic [11:0] res;
    if (v > 999) return 12'hFFF;
    d2 = v / 100;
    d1 = (v / 10) % 10;
    d0 = v % 10;
    res = {4'(d2), 4'(d1), 4'(d0)};
    if (blank && d2 == 0) begin
      res[11:8] = 4'hA;
      if (d1 == 0) res[7:4] = 4'hA;
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input int s);
    check("rst.in_ready", in_ready[s], 1);
    check("rst.out_valid", out_valid[s], 0);
    check("rst.busy", busy[s], 0);
    check("rst.out_dec", out_dec[s], 0);
    check("rst.out_ovf", out_ovf[s], 0);
  endtask

  // One full transaction: accept, wait for the result with a bounded budget,
  // hold it for `hold` cycles while poking in_valid, then hand it off.
  task automatic convert(input int s, input int v, input int hold, input bit noise, input string tag);
    logic [11:0] exp;
    int edges;
    bit stable;
    exp = ref_dec(v, s == 1);
    @(negedge clk);
    check({tag, ".accept_ready"}, in_ready[s], 1);
    in_valid[s] = 1'b1;
    in_bin[s]   = N'(v);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    in_valid[s] = 1'b0;
    while (!out_valid[s] && edges < 64) begin
      if (noise) begin
        in_valid[s] = 1'($urandom);
        in_bin[s]   = N'($urandom);
      end
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    check({tag, ".latency"}, edges, N + 1);
    check({tag, ".out_dec"}, out_dec[s], exp);
    check({tag, ".out_ovf"}, out_ovf[s], (v > 999) ? 1 : 0);
    check({tag, ".busy_done"}, busy[s], 1);
    check({tag, ".ready_done"}, in_ready[s], 0);
    stable = 1'b1;
    for (int k = 0; k < hold; k++) begin
      out_ready[s] = 1'b0;
      in_valid[s]  = 1'b1;
      in_bin[s]    = noise ? N'($urandom) : N'(3);
      @(posedge clk);
      @(negedge clk);
      if (out_dec[s] !== exp || out_ovf[s] !== ((v > 999) ? 1'b1 : 1'b0) ||
          out_valid[s] !== 1'b1 || in_ready[s] !== 1'b0) stable = 1'b0;
    end
    if (hold > 0) check({tag, ".hold_stable"}, stable, 1);
    out_ready[s] = 1'b1;
    in_valid[s]  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready[s] = 1'b0;
    check({tag, ".ready_after"}, in_ready[s], 1);
    check({tag, ".valid_after"}, out_valid[s], 0);
    check({tag, ".busy_after"}, busy[s], 0);
    check({tag, ".dec_kept"}, out_dec[s], exp);
    if (s == 0) conv_cnt++;
  endtask

  initial begin
    in_valid  = '0;
    out_ready = '0;
    in_bin    = '0;
    RST       = 1'b1;
    #1;
    check_reset(0);
    check_reset(1);
    @(negedge clk);
    RST = 1'b0;

    convert(0, 0, 0, 1'b0, "zero");
    convert(0, 999, 0, 1'b0, "max");
    convert(0, 1023, 0, 1'b0, "ovf1023");
    convert(0, 1000, 0, 1'b0, "ovf1000");
    convert(1, 7, 0, 1'b0, "blank7");
    convert(1, 40, 0, 1'b0, "blank40");
    convert(1, 0, 0, 1'b0, "blank0");
    convert(1, 1001, 2, 1'b0, "blank_ovf");
    convert(0, 512, 6, 1'b0, "hold512");

    // Abort a conversion of 345 partway through SHIFT.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_bin[0]   = N'(345);
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("abort.busy_before", busy[0], 1);
    RST = 1'b1;
    #1;
    check_reset(0);
    @(negedge clk);
    RST = 1'b0;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b0) ok = 1'b0;
    end
    check("abort.no_valid", ok, 1);
    convert(0, 345, 0, 1'b0, "after_abort");

    for (int i = 0; i < 1024; i++) perm[i] = i;
    for (int i = 1023; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = perm[i];
      perm[i] = perm[j];
      perm[j] = tmp;
    end
    for (int i = 0; i < 1024; i++) begin
      convert(0, perm[i], $urandom_range(0, 3), 1'b1, "sweep");
    end
    check("handshake_count", hs_cnt, conv_cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
